// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier controller. Borrows the core's shared
// addsub unit for one partial-product add per cycle; valid/ready on both sides.
module mul_seq #(
    parameter int unsigned REG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [REG_WIDTH-1:0] req_a,
    input  logic [REG_WIDTH-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_WIDTH-1:0] rsp_hi,
    output logic [REG_WIDTH-1:0] rsp_lo,
    output logic [REG_WIDTH-1:0] add_ina,
    output logic [REG_WIDTH-1:0] add_inb,
    output logic                 add_invert,
    output logic                 add_carryin,
    input  logic [REG_WIDTH-1:0] add_out,
    input  logic                 add_carryout
);

    localparam int unsigned CNT_W = $clog2(REG_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    generate
        if (REG_WIDTH < 2) begin : g_bad_width
            $error("mul_seq: REG_WIDTH must be at least 2");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [REG_WIDTH-1:0] r_m;
    logic [REG_WIDTH-1:0] r_acc;
    logic [REG_WIDTH-1:0] r_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [REG_WIDTH-1:0] w_m_nxt;
    logic [REG_WIDTH-1:0] w_acc_nxt;
    logic [REG_WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [REG_WIDTH-1:0] w_add_ina;
    logic [REG_WIDTH-1:0] w_add_inb;
    logic                 w_req_ready;
    logic                 w_last_step;

    assign w_req_ready = (r_state == S_IDLE) && !reset;
    assign w_last_step = (r_cnt == CNT_W'(REG_WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_m   <= w_m_nxt;
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next-state, datapath update and adder operand steering
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_add_ina   = '0;
        w_add_inb   = '0;

        case (r_state)
            S_IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_m_nxt     = req_a;
                    w_q_nxt     = req_b;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_add_ina = r_acc;
                w_add_inb = r_q[0] ? r_m : '0;
                // Shift the REG_WIDTH+1-bit partial sum right into acc:q
                {w_acc_nxt, w_q_nxt} = {add_carryout & r_q[0], add_out, r_q[REG_WIDTH-1:1]};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_hi      = r_acc;
    assign rsp_lo      = r_q;
    assign add_ina     = w_add_ina;
    assign add_inb     = w_add_inb;
    assign add_invert  = 1'b0;
    assign add_carryin = 1'b0;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: models the shared addsub unit and scores
// products through an expected-value queue filled at each request accept.
module tb_mul_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_hi;
    logic [W-1:0] rsp_lo;
    logic [W-1:0] add_ina;
    logic [W-1:0] add_inb;
    logic         add_invert;
    logic         add_carryin;
    logic [W-1:0] add_out;
    logic         add_carryout;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          acc_edge_q[$];

    mul_seq #(.REG_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .add_ina(add_ina), .add_inb(add_inb),
        .add_invert(add_invert), .add_carryin(add_carryin),
        .add_out(add_out), .add_carryout(add_carryout)
    );

    always #5 clk = ~clk;

    // Shared addsub unit model
    always_comb begin
        {add_carryout, add_out} = {1'b0, add_ina}
                                + {1'b0, (add_invert ? ~add_inb : add_inb)}
                                + {{W{1'b0}}, add_carryin};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A handshake seen mid-cycle is taken by the next rising edge
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            exp_q.push_back(32'(req_a) * 32'(req_b));
            acc_edge_q.push_back(cyc + 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and collects the response; all judging is left to the caller
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit early_ready, input int stall,
                          output int lat, output logic [31:0] prod,
                          output logic [W-1:0] inb_or, output bit stable);
        lat = -1;
        prod = '0;
        inb_or = '0;
        stable = 1'b1;
        rsp_ready = early_ready;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a = W'($urandom);
        req_b = W'($urandom);
        for (int k = 1; k <= 40; k++) begin
            inb_or |= add_inb;
            tick();
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            prod = {rsp_hi, rsp_lo};
            if (stall > 0) rsp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (!rsp_valid || {rsp_hi, rsp_lo} !== prod || req_ready) stable = 1'b0;
            end
            rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1;
        req_a = 16'h1111;
        req_b = 16'h2222;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_req_ready: got %b want 0", req_ready);
            end
            total++;
            if (rsp_valid !== 1'b0 || {rsp_hi, rsp_lo} !== 32'h0) begin
                bad++;
                $display("FAIL reset_rsp: got valid=%b prod=%h want valid=0 prod=0", rsp_valid, {rsp_hi, rsp_lo});
            end
            total++;
            if (add_ina !== '0 || add_inb !== '0 || add_invert !== 1'b0 || add_carryin !== 1'b0) begin
                bad++;
                $display("FAIL reset_adder: got ina=%h inb=%h inv=%b cin=%b want all 0", add_ina, add_inb, add_invert, add_carryin);
            end
        end
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_no_accept: got %0d accepts want 0", exp_q.size());
        end
    endtask

    task automatic test_product(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit early_ready, input bit inb_zero);
        int          lat;
        logic [31:0] prod;
        logic [31:0] want;
        logic [W-1:0] inb_or;
        bit          stable;
        run_op(a, b, early_ready, 0, lat, prod, inb_or, stable);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL %s_latency: got %0d want 16", name, lat);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard: got empty queue want one entry", name);
        end else begin
            want = exp_q.pop_front();
            if (prod !== want) begin
                bad++;
                $display("FAIL %s_product: got %h want %h", name, prod, want);
            end
        end
        if (inb_zero) begin
            total++;
            if (inb_or !== '0) begin
                bad++;
                $display("FAIL %s_add_inb: got %h want 0000", name, inb_or);
            end
        end
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_return_idle: got ready=%b valid=%b want ready=1 valid=0", name, req_ready, rsp_valid);
        end
    endtask

    task automatic test_basic();
        test_product("basic", 16'h0003, 16'h0005, 1'b1, 1'b0);
        test_product("carry", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        test_product("zero", 16'h0000, 16'hBEEF, 1'b1, 1'b1);
        test_product("ident", 16'h1234, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] prod;
        logic [31:0] want;
        logic [W-1:0] inb_or;
        bit          stable;
        run_op(16'h8000, 16'h0002, 1'b0, 5, lat, prod, inb_or, stable);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 16", lat);
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: got unstable output or early ready want held response");
        end
        total++;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (prod !== want || prod !== 32'h0001_0000) begin
            bad++;
            $display("FAIL bp_product: got %h want %h", prod, 32'h0001_0000);
        end
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          base;
        int          got_n;
        logic [31:0] got[2];
        logic [31:0] want;
        base = acc_edge_q.size();
        got_n = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        req_a = 16'h00FF;
        req_b = 16'h0100;
        req_valid = 1'b1;
        tick();
        req_a = 16'h7FFF;
        req_b = 16'h7FFF;
        for (int k = 0; k < 80 && got_n < 2; k++) begin
            tick();
            if (acc_edge_q.size() >= base + 2) req_valid = 1'b0;
            if (rsp_valid) begin
                got[got_n] = {rsp_hi, rsp_lo};
                got_n++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (got_n != 2 || acc_edge_q.size() != base + 2) begin
            bad++;
            $display("FAIL b2b_count: got rsp=%0d acc=%0d want 2 and 2", got_n, acc_edge_q.size() - base);
        end else begin
            total++;
            if (acc_edge_q[base + 1] - acc_edge_q[base] != 18) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d edges want 18", acc_edge_q[base + 1] - acc_edge_q[base]);
            end
            for (int j = 0; j < 2; j++) begin
                total++;
                want = exp_q.pop_front();
                if (got[j] !== want) begin
                    bad++;
                    $display("FAIL b2b_product%0d: got %h want %h", j, got[j], want);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit seen_valid;
        seen_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        req_a = 16'h1111;
        req_b = 16'h2222;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ready_in_reset: got %b want 0", req_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_idle: got ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid) begin
            bad++;
            $display("FAIL midrst_no_rsp: got rsp_valid=1 want 0 after abort");
        end
        test_product("post_reset", 16'h0002, 16'h0003, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential unsigned REG_WIDTH x REG_WIDTH -> 2*REG_WIDTH shift-add multiplier controller.
- It owns no adder. It drives the core's shared addsub unit through a dedicated operand port, one partial-product add per cycle.
- It sits beside the ALU in the execute stage. A valid/ready request channel accepts operands; a valid/ready response channel returns the product.
- Only one operation is in flight at a time.

Parameters:
REG_WIDTH, 16, operand width; the product is 2*REG_WIDTH bits; must be >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request operands valid
req_ready  output  1  controller can accept a request
req_a  input  REG_WIDTH  multiplicand
req_b  input  REG_WIDTH  multiplier
rsp_valid  output  1  product valid
rsp_ready  input  1  consumer accepts product
rsp_hi  output  REG_WIDTH  product bits [2*REG_WIDTH-1:REG_WIDTH]
rsp_lo  output  REG_WIDTH  product bits [REG_WIDTH-1:0]
add_ina  output  REG_WIDTH  to addsub ina
add_inb  output  REG_WIDTH  to addsub inb
add_invert  output  1  to addsub invert, tied 0
add_carryin  output  1  to addsub carryin, tied 0
add_out  input  REG_WIDTH  from addsub out
add_carryout  input  1  from addsub carryout

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Internal state:
  - m register (REG_WIDTH): latched multiplicand.
  - acc register (REG_WIDTH): high product half.
  - q register (REG_WIDTH): multiplier, which becomes the low product half.
  - cnt counter: ceil(log2(REG_WIDTH+1)) bits.
  - FSM: IDLE, RUN, DONE.
- Reset, at the rising edge with reset=1:
  - state=IDLE; m, acc, q, cnt = 0.
  - rsp_valid=0; rsp_hi=0; rsp_lo=0.
  - req_ready is forced 0 while reset is high, including the reset cycle itself.
- Output decode:
  - req_ready = (state==IDLE) & ~reset.
  - rsp_valid = (state==DONE).
  - rsp_hi = acc; rsp_lo = q. These are held stable while in DONE.
- IDLE:
  - On req_valid & req_ready: m<=req_a, q<=req_b, acc<=0, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN:
  - add_ina = acc.
  - add_inb = q[0] ? m : 0.
  - Each cycle: {acc,q} <= {add_carryout & q[0], add_out, q[REG_WIDTH-1:1]}. This is a right shift of the REG_WIDTH+1-bit sum into acc:q. cnt <= cnt+1.
  - When cnt==REG_WIDTH-1 at the edge, perform the final step and state<=DONE.
  - Exactly REG_WIDTH RUN cycles.
  - req_valid and rsp_ready are ignored in RUN.
- DONE:
  - On rsp_ready: state<=IDLE.
  - Otherwise hold, with outputs stable for backpressure.
  - rsp_valid may not drop without rsp_ready.
- Adder port outside RUN: add_ina = 0 and add_inb = 0. add_invert = 0 and add_carryin = 0 always.
- Latency and throughput:
  - Request accepted at edge N -> rsp_valid high from edge N+REG_WIDTH.
  - With rsp_ready=1, the next request is accepted no earlier than edge N+REG_WIDTH+2, because IDLE must be re-entered first.
  - Peak throughput is one product per REG_WIDTH+2 cycles.
- Arithmetic: unsigned only; full 2*REG_WIDTH-bit result, so there is no overflow. The adder carry-out feeds the bit shifted into the acc MSB.
- Simultaneous events:
  - req_valid during RUN/DONE: req_ready=0, not accepted; the requester holds.
  - rsp_ready asserted before DONE: no effect.
- Reset mid-operation: any state -> IDLE at the reset edge. The partial result is discarded and no rsp_valid is produced for the aborted request.
- Input stability: req_a and req_b are sampled only at the accept edge. Changes afterwards do not affect the result.

Test Plan:
- Basic product: req_a=0x0003, req_b=0x0005, rsp_ready=1 -> rsp_valid at accept edge+16; {rsp_hi,rsp_lo}=0x0000_000F.
- Full-scale carry path: 0xFFFF x 0xFFFF -> 0xFFFE_0001. Checks that add_carryout is shifted into the acc MSB.
- Zero and identity:
  - 0x0000 x 0xBEEF -> 0x0000_0000; add_inb stays 0 throughout RUN.
  - 0x1234 x 0x0001 -> 0x0000_1234.
- Backpressure: 0x8000 x 0x0002 with rsp_ready=0 for 5 cycles after DONE -> rsp_valid held and 0x0001_0000 stable; req_ready=0 throughout; IDLE one edge after rsp_ready=1.
- Back-to-back: req_valid held high with 0x00FF x 0x0100, then 0x7FFF x 0x7FFF -> 0x0000_FF00, then 0x3FFF_0001. The second accept occurs exactly 18 edges after the first.
- Reset mid-RUN: assert reset for one cycle at cnt=7 -> IDLE, req_ready=1 the next cycle, no rsp_valid. A new request 0x0002 x 0x0003 -> 0x0000_0006.
